// File: rtl/uart_pkg.sv
// Shared constants and encodings for the UART transmit controller.
// Port addresses, configuration bit positions and FSM states.
package uart_pkg;

    localparam logic [15:0] DATA_PORT_ADDR = 16'h0000;
    localparam logic [15:0] CFG_PORT_ADDR  = 16'h0001;
    localparam logic [15:0] CLR_PORT_ADDR  = 16'h0002;
    localparam logic [15:0] ENG_PORT_ADDR  = 16'h0000;

    localparam int CFG_W     = 7;
    localparam int BAUD_LSB  = 0;
    localparam int BAUD_MSB  = 3;
    localparam int CFG_EIGHT = 4;
    localparam int CFG_PEN   = 5;
    localparam int CFG_OHEL  = 6;

    localparam logic [1:0] TMO_LAST = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_RDY  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte-load handshake between the transmit controller and the UART engine.
// The controller is master; the engine answers with tx_rdy.
interface uart_tx_ctrl_if;

    logic [15:0] tx_port_id;
    logic        tx_write_strobe;
    logic [7:0]  tx_out_port;
    logic        tx_rdy;

    modport master (
        output tx_port_id,
        output tx_write_strobe,
        output tx_out_port,
        input  tx_rdy
    );

    modport slave (
        input  tx_port_id,
        input  tx_write_strobe,
        input  tx_out_port,
        output tx_rdy
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with flush; head word is visible on rdata_o.
// Push when full and pop when empty are ignored.
module uart_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Processor-side transmit controller: byte FIFO, frame config staging
// and a one-byte-per-busy-period launch FSM toward the UART engine.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter  logic [15:0] DATA_PORT = DATA_PORT_ADDR,
    parameter  logic [15:0] CFG_PORT  = CFG_PORT_ADDR,
    parameter  logic [15:0] CLR_PORT  = CLR_PORT_ADDR,
    parameter  logic [15:0] ENG_PORT  = ENG_PORT_ADDR,
    parameter  int          DEPTH     = 8,
    localparam int          CW        = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   port_id,
    input  logic          write_strobe,
    input  logic [7:0]    out_port,
    uart_tx_ctrl_if.master eng,
    output logic [3:0]    baud_sel,
    output logic          eight,
    output logic          pen,
    output logic          ohel,
    output logic [CW-1:0] fifo_count,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic          overflow,
    output logic          tx_done_int
);

    tx_state_e        state_q, state_d;
    logic [1:0]       tmo_q, tmo_d;
    logic [CFG_W-1:0] cfg_pend_q, cfg_q;
    logic             ovf_q, ovf_d, done_q, done_d;
    logic             wr_data, wr_cfg, wr_clr;
    logic             push, pop, cfg_upd;
    logic [7:0]       head;

    assign wr_data = write_strobe && (port_id == DATA_PORT);
    assign wr_cfg  = write_strobe && (port_id == CFG_PORT);
    assign wr_clr  = write_strobe && (port_id == CLR_PORT);
    assign push    = wr_data && !fifo_full;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (wr_clr),
        .push_i  (push),
        .wdata_i (out_port),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    // A flush between IDLE and LOAD leaves nothing to launch.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && eng.tx_rdy) state_d = LOAD;
            end
            LOAD: begin
                if (fifo_empty) begin
                    state_d = IDLE;
                end else if (eng.tx_rdy) begin
                    state_d = WAIT_BUSY;
                    tmo_d   = '0;
                end
            end
            WAIT_BUSY: begin
                if (!eng.tx_rdy || tmo_q == TMO_LAST) state_d = WAIT_RDY;
                else tmo_d = tmo_q + 2'd1;
            end
            WAIT_RDY: begin
                if (eng.tx_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        eng.tx_write_strobe = 1'b0;
        eng.tx_out_port     = '0;
        pop                 = 1'b0;
        if (state_q == LOAD && eng.tx_rdy && !fifo_empty) begin
            eng.tx_write_strobe = 1'b1;
            eng.tx_out_port     = head;
            pop                 = 1'b1;
        end
    end

    assign eng.tx_port_id = ENG_PORT;

    assign cfg_upd = (state_q == IDLE) && (state_d != LOAD);
    assign ovf_d   = wr_clr ? 1'b0 : ((wr_data && fifo_full) ? 1'b1 : ovf_q);
    assign done_d  = (state_q == WAIT_RDY) && eng.tx_rdy
                   && (wr_clr || (fifo_empty && !push));

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_pend_q <= '0;
            cfg_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (wr_cfg)  cfg_pend_q <= out_port[CFG_W-1:0];
            if (cfg_upd) cfg_q      <= cfg_pend_q;
            ovf_q  <= ovf_d;
            done_q <= done_d;
        end
    end

    assign baud_sel    = cfg_q[BAUD_MSB:BAUD_LSB];
    assign eight       = cfg_q[CFG_EIGHT];
    assign pen         = cfg_q[CFG_PEN];
    assign ohel        = cfg_q[CFG_OHEL];
    assign overflow    = ovf_q;
    assign tx_done_int = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a simple busy-period engine model.
// Launched bytes and done pulses are logged at each rising edge.
module tb_uart_tx_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] port_id;
    logic        write_strobe;
    logic [7:0]  out_port;
    logic [3:0]  baud_sel;
    logic        eight, pen, ohel;
    logic [3:0]  fifo_count;
    logic        fifo_full, fifo_empty, overflow, tx_done_int;

    uart_tx_ctrl_if eng_if ();

    uart_tx_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .port_id      (port_id),
        .write_strobe (write_strobe),
        .out_port     (out_port),
        .eng          (eng_if),
        .baud_sel     (baud_sel),
        .eight        (eight),
        .pen          (pen),
        .ohel         (ohel),
        .fifo_count   (fifo_count),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .overflow     (overflow),
        .tx_done_int  (tx_done_int)
    );

    always #5 clk = ~clk;

    logic        auto_mode, man_rdy, eng_rdy;
    int          busy_len;
    int          busy_cnt;
    int          n_chk, n_fail;
    int          cyc, log_n, done_cnt, viol;
    logic [7:0]  log_b [64];
    int          log_t [64];

    // Engine goes busy for busy_len cycles after each accepted strobe.
    always @(posedge clk) begin
        if (reset) busy_cnt <= 0;
        else if (eng_if.tx_write_strobe) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign eng_rdy       = (busy_cnt == 0);
    assign eng_if.tx_rdy = auto_mode ? eng_rdy : man_rdy;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (eng_if.tx_write_strobe) begin
            if (!eng_if.tx_rdy) viol = viol + 1;
            if (log_n < 64) begin
                log_b[log_n] = eng_if.tx_out_port;
                log_t[log_n] = cyc;
                log_n        = log_n + 1;
            end
        end
        if (tx_done_int) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] p, input logic [7:0] d);
        port_id      = p;
        out_port     = d;
        write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int tgt, input int lim);
        for (int i = 0; i < lim && done_cnt < tgt; i++) @(negedge clk);
        chk(tag, done_cnt, tgt);
    endtask

    int base;

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; log_n = 0;
        done_cnt = 0; viol = 0;
        reset = 1'b1; port_id = '0; write_strobe = 1'b0; out_port = '0;
        auto_mode = 1'b1; man_rdy = 1'b1; busy_len = 5;
        repeat (3) @(negedge clk);
        chk("rst_count", fifo_count, 0);
        chk("rst_flags", {fifo_empty, fifo_full, overflow, tx_done_int}, 4'b1000);
        chk("rst_strobe", {eng_if.tx_write_strobe, eng_if.tx_out_port}, 9'h000);
        chk("rst_cfg", {ohel, pen, eight, baud_sel}, 7'h00);
        chk("eng_port", eng_if.tx_port_id, 16'h0000);
        reset = 1'b0;
        @(negedge clk);

        // Single byte: strobe two cycles after the write.
        wr(16'h0000, 8'h31);
        chk("lat_count1", fifo_count, 1);
        chk("lat_nostrobe", eng_if.tx_write_strobe, 1'b0);
        @(negedge clk);
        chk("lat_strobe", {eng_if.tx_write_strobe, eng_if.tx_out_port}, 9'h131);
        @(negedge clk);
        chk("lat_empty", {fifo_empty, fifo_count}, 5'h10);
        wait_done("lat_done", 1, 100);

        // Config staging across an in-flight frame.
        wr(16'h0001, 8'h05);
        @(negedge clk);
        chk("cfg_idle", {ohel, pen, eight, baud_sel}, 7'h05);
        busy_len = 20;
        wr(16'h0000, 8'h41);
        repeat (2) @(negedge clk);
        wr(16'h0001, 8'h3A);
        repeat (5) @(negedge clk);
        chk("cfg_hold", {ohel, pen, eight, baud_sel}, 7'h05);
        wait_done("cfg_done", 2, 200);
        repeat (2) @(negedge clk);
        chk("cfg_new", {ohel, pen, eight, baud_sel}, 7'h3A);

        // Three bytes with a 20-cycle engine.
        base = log_n;
        wr(16'h0000, 8'h51);
        wr(16'h0000, 8'h52);
        wr(16'h0000, 8'h53);
        chk("q3_count", fifo_count, 2);
        wait_done("q3_done", 3, 300);
        repeat (10) @(negedge clk);
        chk("q3_onedone", done_cnt, 3);
        chk("q3_nstrobe", log_n - base, 3);
        for (int i = 0; i < 3; i++)
            chk("q3_byte", log_b[base + i], 8'h51 + 8'(i));

        // Nine writes into a stalled engine.
        auto_mode = 1'b0; man_rdy = 1'b0;
        base = log_n;
        for (int i = 0; i < 9; i++) wr(16'h0000, 8'h60 + 8'(i));
        chk("ovf_count", fifo_count, 8);
        chk("ovf_flags", {fifo_full, fifo_empty, overflow}, 3'b101);
        busy_len = 3; auto_mode = 1'b1;
        wait_done("ovf_done", 4, 400);
        chk("ovf_nstrobe", log_n - base, 8);
        for (int i = 0; i < 8; i++)
            chk("ovf_byte", log_b[base + i], 8'h60 + 8'(i));
        chk("ovf_sticky", overflow, 1'b1);
        wr(16'h0002, 8'h00);
        chk("clr_ovf", overflow, 1'b0);

        // Flush of queued bytes before they launch.
        auto_mode = 1'b0; man_rdy = 1'b0;
        base = log_n;
        wr(16'h0000, 8'hA1);
        wr(16'h0000, 8'hA2);
        wr(16'h0002, 8'h00);
        chk("flush_count", {fifo_empty, fifo_count}, 5'h10);
        man_rdy = 1'b1;
        repeat (20) @(negedge clk);
        chk("flush_nostrobe", log_n - base, 0);

        // Engine ignores the strobe: timeout, no duplicate.
        base = log_n;
        wr(16'h0000, 8'h71);
        wr(16'h0000, 8'h72);
        repeat (30) @(negedge clk);
        chk("stuck_nstrobe", log_n - base, 2);
        chk("stuck_b0", log_b[base], 8'h71);
        chk("stuck_b1", log_b[base + 1], 8'h72);
        chk("stuck_gap", log_t[base + 1] - log_t[base], 7);
        chk("stuck_done", done_cnt, 5);

        // Reset while waiting on the engine with two bytes queued.
        auto_mode = 1'b1; busy_len = 20;
        wr(16'h0000, 8'h81);
        wr(16'h0000, 8'h82);
        wr(16'h0000, 8'h83);
        repeat (3) @(negedge clk);
        chk("mrst_pre", fifo_count, 2);
        base = log_n;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_count", {fifo_empty, fifo_full, fifo_count}, 6'h20);
        chk("mrst_cfg", {ohel, pen, eight, baud_sel}, 7'h00);
        repeat (30) @(negedge clk);
        chk("mrst_nostrobe", log_n - base, 0);
        chk("rdy_viol", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
